// File: rtl/load_store_unit.sv
// Sequential load/store unit: one request per transaction, valid/ready bus
// handshake, lane-aligned and sign/zero-extended load results.
module load_store_unit #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            resp_valid,
  output logic [SIZE-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [2:0]      funct3_q, funct3_nxt;
  logic [1:0]      off_q, off_nxt;

  logic            req_ready_nxt;
  logic            resp_valid_nxt;
  logic [SIZE-1:0] resp_rdata_nxt;
  logic            resp_err_nxt;
  logic            mem_valid_nxt;
  logic            mem_we_nxt;
  logic [SIZE-1:0] mem_addr_nxt;
  logic [3:0]      mem_wstrb_nxt;
  logic [SIZE-1:0] mem_wdata_nxt;

  logic            req_legal;
  logic            req_aligned;
  logic [SIZE-1:0] fmt_wdata;
  logic [3:0]      fmt_wstrb;
  logic [SIZE-1:0] ld_shifted;
  logic [SIZE-1:0] ld_data;

  // Request decode: width legality, alignment and store lane formatting
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    fmt_wdata   = req_wdata;
    fmt_wstrb   = 4'b1111;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = ~req_we;
      default:                req_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   req_aligned = ~req_addr[0];
      2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{req_wdata[7:0]}};
        fmt_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{req_wdata[15:0]}};
        fmt_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        fmt_wdata = req_wdata;
        fmt_wstrb = 4'b1111;
      end
    endcase
    if (!req_we) fmt_wstrb = 4'b0000;
  end

  // Load extraction: shift the addressed lane down, then extend
  always_comb begin
    ld_shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    funct3_nxt     = funct3_q;
    off_nxt        = off_q;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wstrb_nxt  = mem_wstrb;
    mem_wdata_nxt  = mem_wdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          funct3_nxt    = req_funct3;
          off_nxt       = req_addr[1:0];
          mem_we_nxt    = req_we;
          mem_addr_nxt  = {req_addr[SIZE-1:2], 2'b00};
          mem_wstrb_nxt = fmt_wstrb;
          mem_wdata_nxt = fmt_wdata;
          if (req_legal && req_aligned) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt      = DONE;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_nxt      = DONE;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = mem_we ? '0 : ld_data;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    req_ready_nxt  = (state_nxt == IDLE);
    mem_valid_nxt  = (state_nxt == ACCESS);
    resp_valid_nxt = (state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      funct3_q   <= funct3_nxt;
      off_q      <= off_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      mem_valid  <= mem_valid_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fails;

  load_store_unit #(.SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction, starting 1ns after a rising edge with the unit idle
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int waits, input logic exp_err,
                     input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                     input logic [3:0] exp_strb);
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5555_AAAA;
    req_funct3 = 3'b111;
    if (!exp_err) begin
      for (int i = 0; i <= waits; i++) begin
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        chk({tag, ".no_early_resp"}, 32'(resp_valid), 32'd0);
        mem_ready = (i == waits);
        mem_rdata = (i == waits) ? rdata : 32'hA5A5_A5A5;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end else begin
      chk({tag, ".no_bus"}, 32'(mem_valid), 32'd0);
    end
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, ".ready_done"}, 32'(req_ready), 32'd0);
    chk({tag, ".bus_idle_done"}, 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, ".rdata_hold"}, resp_rdata, exp_rd);
    chk({tag, ".err_hold"}, 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;

    #12;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // tag, we, f3, addr, wdata, rdata, waits, err, rdata_exp, wdata_exp, wstrb_exp
    txn("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 32'h0, 4'b0000);
    txn("lw_mis", 1'b0, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000);
    txn("lhu",  1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 1'b0, 32'h0000_8001, 32'h0, 4'b0000);
    txn("f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000);
    txn("lh",   1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 1'b0, 32'hFFFF_8001, 32'h0, 4'b0000);
    txn("sh",   1'b1, 3'b001, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 32'h0, 32'hBEEF_BEEF, 4'b1100);
    txn("lbu",  1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9A00, 1, 1'b0, 32'h0000_009A, 32'h0, 4'b0000);
    txn("sw_wait", 1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 32'h0, 5, 1'b0, 32'h0, 32'h1122_3344, 4'b1111);
    txn("lh_mis", 1'b0, 3'b001, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000);
    txn("sb",   1'b1, 3'b000, 32'h0000_0007, 32'h0000_00AB, 32'h0, 0, 1'b0, 32'h0, 32'hABAB_ABAB, 4'b1000);
    txn("sbu_ill", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0000);

    // Reset in the middle of an access
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort.mem_valid_pre", 32'(mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.mem_valid_async", 32'(mem_valid), 32'd0);
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort.no_resp", 32'(resp_valid), 32'd0);
      chk("abort.idle_bus", 32'(mem_valid), 32'd0);
    end
    txn("lw_post", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 32'h0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
